// File: rtl/float_mult_pipe.sv
// rtl/float_mult_pipe.sv - three-stage parametrised float multiplier with valid/ready stall and ovf/udf flags
// Define FLOAT_MULT_ROUND_EN for round-to-nearest-even; otherwise the product mantissa is truncated.
module float_mult_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 6,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_1_i,
    input  logic [W-1:0] data_2_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_mult_o,
    output logic         ovf_o,
    output logic         udf_o
);
    localparam int EW = EXP_W + 2;
    localparam int MW = MAN_W + 1;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EMIN = EW'(1);

    // The whole pipe moves as one unit whenever the output slot is free or being consumed.
    logic adv;
    assign adv     = ready_i | ~valid_o;
    assign ready_o = adv;

    logic [EXP_W-1:0]     exp_a, exp_b;
    logic signed [EW-1:0] exp_sum;
    assign exp_a   = data_1_i[W-2:MAN_W];
    assign exp_b   = data_2_i[W-2:MAN_W];
    assign exp_sum = signed'({2'b00, exp_a}) + signed'({2'b00, exp_b}) - BIAS;

    logic                 s1_valid, s1_sign, s1_zero;
    logic signed [EW-1:0] s1_exp;
    logic [MW-1:0]        s1_ma, s1_mb;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_exp   <= '0;
            s1_ma    <= '0;
            s1_mb    <= '0;
        end else if (adv) begin
            s1_valid <= valid_i;
            s1_sign  <= data_1_i[W-1] ^ data_2_i[W-1];
            s1_zero  <= (exp_a == '0) | (exp_b == '0);
            s1_exp   <= exp_sum;
            s1_ma    <= {1'b1, data_1_i[MAN_W-1:0]};
            s1_mb    <= {1'b1, data_2_i[MAN_W-1:0]};
        end
    end

    logic                 s2_valid, s2_sign, s2_zero;
    logic signed [EW-1:0] s2_exp;
    logic [PW-1:0]        s2_prod;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_exp   <= '0;
            s2_prod  <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_zero  <= s1_zero;
            s2_exp   <= s1_exp;
            s2_prod  <= PW'(s1_ma) * PW'(s1_mb);
        end
    end

    // Normalise: a product >= 2.0 shifts the field up one bit and bumps the exponent.
    logic                 norm_hi;
    logic [MAN_W-1:0]     man_n, man_r;
    logic signed [EW-1:0] exp_n, exp_r;
    assign norm_hi = s2_prod[PW-1];
    assign man_n   = norm_hi ? s2_prod[PW-2 -: MAN_W] : s2_prod[PW-3 -: MAN_W];
    assign exp_n   = s2_exp + EW'(norm_hi);

`ifdef FLOAT_MULT_ROUND_EN
    logic guard, sticky, round_up, carry;
    assign guard    = norm_hi ? s2_prod[MAN_W] : s2_prod[MAN_W-1];
    assign sticky   = norm_hi ? |s2_prod[MAN_W-1:0] : |s2_prod[MAN_W-2:0];
    assign round_up = guard & (sticky | man_n[0]);
    assign {carry, man_r} = {1'b0, man_n} + (MAN_W + 1)'(round_up);
    assign exp_r    = exp_n + EW'(carry);
`else
    logic unused_low;
    assign unused_low = ^s2_prod[MAN_W-1:0];
    assign man_r      = man_n;
    assign exp_r      = exp_n;
`endif

    logic [W-1:0] res_d;
    logic         ovf_d, udf_d;

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        udf_d = 1'b0;
        if (s2_valid && !s2_zero) begin
            if (exp_r > EMAX) begin
                res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
                ovf_d = 1'b1;
            end else if (exp_r < EMIN) begin
                udf_d = 1'b1;
            end else begin
                res_d = {s2_sign, exp_r[EXP_W-1:0], man_r};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o     <= 1'b0;
            data_mult_o <= '0;
            ovf_o       <= 1'b0;
            udf_o       <= 1'b0;
        end else if (adv) begin
            valid_o     <= s2_valid;
            data_mult_o <= res_d;
            ovf_o       <= ovf_d;
            udf_o       <= udf_d;
        end
    end
endmodule

// File: tb/tb_float_mult_pipe.sv
// tb/tb_float_mult_pipe.sv - self-checking bench for float_mult_pipe (directed, backpressure, reset, random)
module tb_float_mult_pipe;
    localparam int EXP_W = 5;
    localparam int MAN_W = 6;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

    logic         clk = 1'b0;
    logic         rst_i, valid_i, ready_i;
    logic         ready_o, valid_o, ovf_o, udf_o;
    logic [W-1:0] data_1_i, data_2_i, data_mult_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    float_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_1_i   (data_1_i),
        .data_2_i   (data_2_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_mult_o(data_mult_o),
        .ovf_o      (ovf_o),
        .udf_o      (udf_o)
    );

    // Reference: exact integer product of the significands, scaled and rounded by value.
    function automatic logic [W+1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b);
        int     ea, eb, e, shift;
        longint ma, mb, p, mant;
        logic   s;
`ifdef FLOAT_MULT_ROUND_EN
        longint rem, half;
`endif
        ea = int'(a[W-2:MAN_W]);
        eb = int'(b[W-2:MAN_W]);
        if (ea == 0 || eb == 0) return '0;
        s  = a[W-1] ^ b[W-1];
        ma = (longint'(1) << MAN_W) + longint'(a[MAN_W-1:0]);
        mb = (longint'(1) << MAN_W) + longint'(b[MAN_W-1:0]);
        p  = ma * mb;
        e  = ea + eb - BIAS;
        if (p >= (longint'(1) << (2 * MAN_W + 1))) begin
            shift = MAN_W + 1;
            e = e + 1;
        end else begin
            shift = MAN_W;
        end
        mant = p >> shift;
`ifdef FLOAT_MULT_ROUND_EN
        rem  = p - (mant << shift);
        half = longint'(1) << (shift - 1);
        if (rem > half || (rem == half && mant[0])) mant = mant + 1;
`endif
        if (mant == (longint'(1) << (MAN_W + 1))) begin
            mant = mant >> 1;
            e = e + 1;
        end
        if (e > (1 << EXP_W) - 1) return {2'b10, s, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
        if (e < 1) return {2'b01, {W{1'b0}}};
        return {2'b00, s, e[EXP_W-1:0], mant[MAN_W-1:0]};
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W+1:0] res, output int lat);
        ready_i  = 1'b1;
        valid_i  = 1'b1;
        data_1_i = a;
        data_2_i = b;
        lat = 0;
        do begin
            @(posedge clk); #1;
            valid_i = 1'b0;
            lat++;
        end while (!valid_o && lat < 10);
        res = {ovf_o, udf_o, data_mult_o};
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        data_1_i = '0; data_2_i = '0;
        #3;
        tests++;
        if ({valid_o, ovf_o, udf_o, data_mult_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b o=%b u=%b d=%h required all zero", valid_o, ovf_o, udf_o, data_mult_o);
        end
        tests++;
        if (ready_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b required 1", ready_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            fails++;
            $display("FAIL post_reset: got ready=%b valid=%b required 1 0", ready_o, valid_o);
        end
    endtask

    typedef struct {
        logic [W-1:0] a, b, r;
        logic ov, un;
    } vec_t;

    task automatic test_directed();
        vec_t         v[6];
        logic [W+1:0] res;
        int           lat;
        v[0] = '{a: 12'h3E0, b: 12'h3E0, r: 12'h408, ov: 1'b0, un: 1'b0};
        v[1] = '{a: 12'hC00, b: 12'h420, r: 12'hC60, ov: 1'b0, un: 1'b0};
        v[2] = '{a: 12'h000, b: 12'hC60, r: 12'h000, ov: 1'b0, un: 1'b0};
        v[3] = '{a: 12'h780, b: 12'h780, r: 12'h7FF, ov: 1'b1, un: 1'b0};
        v[4] = '{a: 12'h040, b: 12'h040, r: 12'h000, ov: 1'b0, un: 1'b1};
`ifdef FLOAT_MULT_ROUND_EN
        v[5] = '{a: 12'h3C1, b: 12'h3E0, r: 12'h3E2, ov: 1'b0, un: 1'b0};
`else
        v[5] = '{a: 12'h3C1, b: 12'h3E0, r: 12'h3E1, ov: 1'b0, un: 1'b0};
`endif
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].a, v[i].b, res, lat);
            tests++;
            if (res !== {v[i].ov, v[i].un, v[i].r}) begin
                fails++;
                $display("FAIL directed_%0d %h*%h: got ovf=%b udf=%b d=%h required ovf=%b udf=%b d=%h",
                         i, v[i].a, v[i].b, res[W+1], res[W], res[W-1:0], v[i].ov, v[i].un, v[i].r);
            end
            tests++;
            if (lat != 3) begin
                fails++;
                $display("FAIL latency_%0d: got %0d required 3", i, lat);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] pa[5], pb[5];
        logic [W+1:0] q[$];
        logic [W+1:0] first, e;
        int           idx, got;
        for (int i = 0; i < 5; i++) begin
            pa[i] = W'($urandom);
            pb[i] = W'($urandom);
        end
        first = ref_mult(pa[0], pb[0]);
        idx = 0; got = 0;
        ready_i = 1'b0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (c == 10) ready_i = 1'b1;
            valid_i  = (idx < 5);
            data_1_i = pa[idx < 5 ? idx : 4];
            data_2_i = pb[idx < 5 ? idx : 4];
            #1;
            if (c >= 4 && c <= 9) begin
                tests++;
                if (ready_o !== 1'b0 || valid_o !== 1'b1 || {ovf_o, udf_o, data_mult_o} !== first) begin
                    fails++;
                    $display("FAIL stall_hold_c%0d: got ready=%b valid=%b d=%h required 0 1 %h",
                             c, ready_o, valid_o, data_mult_o, first[W-1:0]);
                end
            end
            if (valid_o && ready_i) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra_result: got d=%h required none", data_mult_o);
                end else begin
                    e = q.pop_front();
                    if ({ovf_o, udf_o, data_mult_o} !== e) begin
                        fails++;
                        $display("FAIL bp_order_%0d: got %h required %h", got, {ovf_o, udf_o, data_mult_o}, e);
                    end
                end
                got++;
            end
            if (valid_i && ready_o) begin
                q.push_back(ref_mult(pa[idx], pb[idx]));
                idx++;
            end
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        tests++;
        if (got != 5 || idx != 5) begin
            fails++;
            $display("FAIL bp_count: got %0d results %0d inputs required 5 5", got, idx);
        end
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (valid_o !== 1'b0) begin
            fails++;
            $display("FAIL bp_duplicate: got valid=%b required 0", valid_o);
        end
    endtask

    task automatic test_reset_midstream();
        logic [W-1:0] a, b;
        logic [W+1:0] res;
        int           lat, stale;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_i  = 1'b1;
            data_1_i = W'($urandom);
            data_2_i = W'($urandom);
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        tests++;
        if ({valid_o, ovf_o, udf_o, data_mult_o} !== '0) begin
            fails++;
            $display("FAIL midreset_async: got v=%b d=%h required 0 000", valid_o, data_mult_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
        stale = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (valid_o) stale++;
        end
        tests++;
        if (stale != 0) begin
            fails++;
            $display("FAIL midreset_stale: got %0d stale results required 0", stale);
        end
        a = 12'h3E0; b = 12'hC00;
        run_op(a, b, res, lat);
        tests++;
        if (res !== ref_mult(a, b) || lat != 3) begin
            fails++;
            $display("FAIL midreset_next: got %h lat %0d required %h lat 3", res, lat, ref_mult(a, b));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [W+1:0] q[$];
        logic [W+1:0] e, held;
        logic         hold;
        int           bad, bad_rdy, bad_hold;
        bad = 0; bad_rdy = 0; bad_hold = 0; hold = 1'b0; held = '0;
        for (int c = 0; c < 400; c++) begin
            valid_i  = ($urandom_range(0, 9) < 7);
            ready_i  = ($urandom_range(0, 9) < 7);
            data_1_i = W'($urandom);
            data_2_i = W'($urandom);
            #1;
            tests++;
            if (ready_o !== (ready_i | ~valid_o)) begin
                fails++;
                bad_rdy++;
                if (bad_rdy < 5) $display("FAIL rand_ready_c%0d: got %b required %b", c, ready_o, ready_i | ~valid_o);
            end
            if (hold) begin
                tests++;
                if ({ovf_o, udf_o, data_mult_o} !== held || valid_o !== 1'b1) begin
                    fails++;
                    bad_hold++;
                    if (bad_hold < 5) $display("FAIL rand_hold_c%0d: got %h required %h", c, {ovf_o, udf_o, data_mult_o}, held);
                end
            end
            if (valid_o && ready_i) begin
                tests++;
                e = (q.size() == 0) ? {(W+2){1'bx}} : q.pop_front();
                if ({ovf_o, udf_o, data_mult_o} !== e) begin
                    fails++;
                    bad++;
                    if (bad < 5) $display("FAIL rand_result_c%0d: got %h required %h", c, {ovf_o, udf_o, data_mult_o}, e);
                end
            end
            if (valid_i && ready_o) q.push_back(ref_mult(data_1_i, data_2_i));
            hold = valid_o && !ready_i;
            held = {ovf_o, udf_o, data_mult_o};
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (valid_o) begin
                tests++;
                e = (q.size() == 0) ? {(W+2){1'bx}} : q.pop_front();
                if ({ovf_o, udf_o, data_mult_o} !== e) begin
                    fails++;
                    $display("FAIL rand_drain: got %h required %h", {ovf_o, udf_o, data_mult_o}, e);
                end
            end
            @(posedge clk); #1;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL rand_lost: got %0d results missing required 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
